// File: rtl/video_shifter_if.sv
// Bundle between the timing generator, video RAM / character ROM and the
// pixel serialiser. The shifter takes the slave view; whatever feeds it
// (timing generator plus memories, or a bench) takes the master view.
interface video_shifter_if #(
    parameter int CHAR_ADDR_W = 12
);
    logic                   ldps_n;
    logic                   vid7m;
    logic                   sega;
    logic                   segb;
    logic                   segc;
    logic                   gr2;
    logic                   hires_mode;
    logic                   col80;
    logic                   dhires_mode;
    logic                   altchar;
    logic                   hblank;
    logic                   vblank;
    logic                   wndw_n;
    logic [7:0]             ram_data_main;
    logic [7:0]             ram_data_aux;
    logic [CHAR_ADDR_W-1:0] char_rom_addr;
    logic [7:0]             char_rom_data;
    logic                   video;
    logic                   hblank_out;
    logic                   vblank_out;
    logic                   color_line;

    modport master (
        output ldps_n, vid7m, sega, segb, segc, gr2,
               hires_mode, col80, dhires_mode, altchar,
               hblank, vblank, wndw_n,
               ram_data_main, ram_data_aux, char_rom_data,
        input  char_rom_addr, video, hblank_out, vblank_out, color_line
    );

    modport slave (
        input  ldps_n, vid7m, sega, segb, segc, gr2,
               hires_mode, col80, dhires_mode, altchar,
               hblank, vblank, wndw_n,
               ram_data_main, ram_data_aux, char_rom_data,
        output char_rom_addr, video, hblank_out, vblank_out, color_line
    );
endinterface

// File: rtl/video_shifter.sv
// Apple //e style pixel serialiser. Takes the fetched video bytes and the
// load/shift strobes from the timing generator, shapes each byte into dots
// according to the display mode and shifts one dot per 14M cycle onto video.
module video_shifter #(
    parameter int FLASH_DIV   = 16,
    parameter int CHAR_ADDR_W = 12
) (
    input  logic           clk_14m,
    input  logic           reset,
    video_shifter_if.slave bus
);

    localparam int              FC_W    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_DIV - 1);

    logic            ldps_q;
    logic            vblank_q;
    logic            load;
    logic            shift_en;
    logic            vblank_rise;

    logic [FC_W-1:0] flash_cnt;
    logic            flash_phase;

    logic            half_sel;
    logic [7:0]      code_sel;
    logic [7:0]      code_rom;

    logic            inverse;
    logic [6:0]      text_pat;
    logic [3:0]      nibble;
    logic [6:0]      lores_base;
    logic [6:0]      lores_pat;
    logic [6:0]      main_pat;
    logic            wide;
    logic            delay_next;
    logic [13:0]     load_word;

    logic [13:0]     shreg;
    logic            wndw_q;
    logic            delay_q;
    logic            load_q;
    logic            hblank_cap;
    logic            vblank_cap;
    logic            gr2_cap;
    logic            dot_now;
    logic            dot_prev;

    // Bit 7 of the ROM row is not a dot; it is deliberately ignored.
    logic            unused_rom_bit;
    assign unused_rom_bit = bus.char_rom_data[7];

    assign load        = ~bus.ldps_n & ldps_q;
    assign shift_en    = ~bus.vid7m;
    assign vblank_rise = bus.vblank & ~vblank_q;
    assign wide        = bus.col80 | bus.dhires_mode;
    assign dot_now     = shreg[0] & ~wndw_q;

    // Character code for the ROM lookup, with the primary-set remap of 0x40-0x7F.
    always_comb begin
        code_sel = bus.ram_data_main;
        code_rom = 8'h00;
        if (bus.col80 && half_sel) begin
            code_sel = bus.ram_data_aux;
        end
        if (!bus.altchar && (code_sel[7:6] == 2'b01)) begin
            code_rom = {2'b00, code_sel[5:0]};
        end else begin
            code_rom = code_sel;
        end
    end

    // Dot pattern for the single-byte (40-column) modes.
    always_comb begin
        inverse    = 1'b0;
        text_pat   = bus.char_rom_data[6:0];
        nibble     = bus.ram_data_main[3:0];
        lores_base = 7'h00;
        lores_pat  = 7'h00;
        main_pat   = 7'h00;

        if (bus.ram_data_main[7:6] == 2'b00) begin
            inverse = 1'b1;
        end else if ((bus.ram_data_main[7:6] == 2'b01) && !bus.altchar && flash_phase) begin
            inverse = 1'b1;
        end
        if (inverse) begin
            text_pat = ~bus.char_rom_data[6:0];
        end

        if (bus.segc) begin
            nibble = bus.ram_data_main[7:4];
        end
        lores_base = {nibble[0], nibble[1], nibble[2], nibble[3],
                      nibble[0], nibble[1], nibble[2]};
        // Odd columns (H0 set) see the colour phase advanced by two dots.
        if (bus.sega) begin
            lores_pat = {lores_base[1:0], lores_base[6:2]};
        end else begin
            lores_pat = lores_base;
        end

        if (!bus.gr2) begin
            main_pat = text_pat;
        end else if (bus.hires_mode) begin
            main_pat = bus.ram_data_main[6:0];
        end else begin
            main_pat = lores_pat;
        end
    end

    // Parallel word presented to the shifter and the hires half-dot delay decision.
    always_comb begin
        load_word  = {7'h00, main_pat};
        delay_next = 1'b0;
        if (wide) begin
            load_word = {bus.ram_data_main[6:0], bus.ram_data_aux[6:0]};
        end
        if (bus.gr2 && bus.hires_mode && !bus.dhires_mode) begin
            delay_next = bus.ram_data_main[7];
        end
    end

    // Edge history for the load strobe and vertical blanking.
    always_ff @(posedge clk_14m) begin
        if (reset) begin
            ldps_q   <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            ldps_q   <= bus.ldps_n;
            vblank_q <= bus.vblank;
        end
    end

    // Flash timebase: phase flips once every FLASH_DIV frames.
    always_ff @(posedge clk_14m) begin
        if (reset) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (vblank_rise) begin
            if (flash_cnt == FC_LAST) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

    // Character ROM address, refreshed every cycle; in 80 columns the half-select alternates aux/main.
    always_ff @(posedge clk_14m) begin
        if (reset) begin
            half_sel          <= 1'b0;
            bus.char_rom_addr <= '0;
        end else begin
            half_sel          <= load ? 1'b0 : ~half_sel;
            bus.char_rom_addr <= CHAR_ADDR_W'({code_rom, bus.segc, bus.segb, bus.sega});
        end
    end

    // Shift register; a load takes priority over a shift in the same cycle.
    always_ff @(posedge clk_14m) begin
        if (reset) begin
            shreg      <= '0;
            wndw_q     <= 1'b0;
            delay_q    <= 1'b0;
            hblank_cap <= 1'b0;
            vblank_cap <= 1'b0;
            gr2_cap    <= 1'b0;
        end else if (load) begin
            shreg      <= load_word;
            wndw_q     <= bus.wndw_n;
            delay_q    <= delay_next;
            hblank_cap <= bus.hblank;
            vblank_cap <= bus.vblank;
            gr2_cap    <= bus.gr2;
        end else if (shift_en) begin
            shreg <= {1'b0, shreg[13:1]};
        end
    end

    // Output stage: dot register, optional half-dot delay, blanking launched with the first dot.
    always_ff @(posedge clk_14m) begin
        if (reset) begin
            load_q         <= 1'b0;
            dot_prev       <= 1'b0;
            bus.video      <= 1'b0;
            bus.hblank_out <= 1'b1;
            bus.vblank_out <= 1'b1;
            bus.color_line <= 1'b0;
        end else begin
            load_q    <= load;
            dot_prev  <= dot_now;
            bus.video <= delay_q ? dot_prev : dot_now;
            if (load_q) begin
                bus.hblank_out <= hblank_cap;
                bus.vblank_out <= vblank_cap;
                bus.color_line <= gr2_cap;
            end
        end
    end

endmodule

// File: doc/video_shifter.md
Name: video_shifter

Overview:
- Pixel serialiser directly downstream of the Apple //e timing generator.
- Consumes the load/shift strobes, row segments, mode flags and blanking from the timing generator, plus the main/aux RAM bytes fetched at VIDEO_ADDRESS.
- Performs the character-ROM lookup, flash/inverse handling and mode-dependent byte-to-dot shaping.
- Emits one serial video bit per CLK_14M, plus aligned blanking, for the downstream composite/RGB encoder.

Parameters:
- FLASH_DIV, 16, number of VBLANK rising edges between flash-phase toggles.
- CHAR_ADDR_W, 12, width of the character-ROM address.

Ports:
- CLK_14M  in  1  14.31818 MHz master clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- LDPS_N  in  1  load-parallel-to-shifter strobe, active low.
- VID7M  in  1  shift enable; shift occurs on every cycle VID7M is sampled 0 (toggling gives 7 MHz, held 0 gives 14 MHz).
- SEGA, SEGB, SEGC  in  1 each  character row bits in text; SEGA = H0 and SEGC = V2 in graphics.
- GR2  in  1  graphics mode, pipeline-aligned.
- HIRES_MODE, COL80, DHIRES_MODE, ALTCHAR  in  1 each  soft-switch mode flags.
- HBLANK, VBLANK, WNDW_N  in  1 each  blanking inputs.
- RAM_DATA_MAIN, RAM_DATA_AUX  in  8 each  fetched video bytes; stable at least 3 cycles before LDPS_N falls.
- CHAR_ROM_ADDR  out  CHAR_ADDR_W  registered character-ROM address.
- CHAR_ROM_DATA  in  8  ROM output; valid 1 cycle after CHAR_ROM_ADDR.
- VIDEO  out  1  serial dot.
- HBLANK_OUT, VBLANK_OUT  out  1 each  blanking aligned to VIDEO.
- COLOR_LINE  out  1  high on graphics lines (enables colour burst).

Behaviour:
- Reset: all registers clear. VIDEO=0, CHAR_ROM_ADDR=0, HBLANK_OUT=1, VBLANK_OUT=1, COLOR_LINE=0, flash phase=0, flash counter=0, shift register=0. Reset asserted mid-line aborts the current byte; output resumes at the next load after release.
- Load detect: load = LDPS_N sampled 0 while its previous registered value was 1 (falling edge). LDPS_N held low loads only once.
- Char ROM, every cycle: CHAR_ROM_ADDR <= {code, SEGC, SEGB, SEGA}. code is RAM_DATA_MAIN in 40-column mode; it is the byte selected by the aux/main half-select flop in 80-column mode. With ALTCHAR=0, codes 0x40-0x7F are remapped to 0x00-0x3F for ROM addressing.
- Text pattern: p = ~CHAR_ROM_DATA[6:0] for inverse, i.e. code[7:6]=00, or code[7:6]=01 with ALTCHAR=0 and flash phase=1. Otherwise p = CHAR_ROM_DATA[6:0].
- Lores pattern: nibble = SEGC ? byte[7:4] : byte[3:0]. Pattern is {n0,n1,n2,n3,n0,n1,n2}, rotated by 2 when SEGA=1.
- Hires pattern: byte[6:0]. Delay flag = byte[7], applied only when DHIRES_MODE=0.
- 14-bit shift register on load:
  - COL80 or DHIRES_MODE: {main[6:0], aux[6:0]}; aux bit0 shifts out first. 14 shifts per load.
  - Otherwise: {7'b0, main pattern}. 7 shifts per load.
- Shift: when VID7M==0, shreg >>= 1 with a 0 fill.
- Output: VIDEO <= shreg[0], gated to 0 when WNDW_N was 1 at the last load.
- Hires delay: when the delay flag is set, VIDEO takes a one-cycle delayed copy (half a 7 MHz dot). The flag is re-evaluated at every load.
- Blanking alignment: HBLANK_OUT, VBLANK_OUT and COLOR_LINE (=GR2) update only at load, so they stay aligned with the first dot of the byte.
- Flash counter increments on each VBLANK rising edge. At FLASH_DIV-1 it wraps to 0 and the flash phase toggles. If a VBLANK edge coincides with RESET, RESET wins.
- Load coincident with shift: the load wins and that cycle's shift is dropped.
- Pipeline latency: LDPS_N falling edge to first dot of the byte on VIDEO = 2 CLK_14M cycles (3 with the hires delay).

Test Plan:
- Reset: hold RESET 3 cycles mid-line, then release → VIDEO=0, HBLANK_OUT=1, flash phase=0; the first load after release produces correct dots.
- 40-col text: code 0xC1, ROM row data 0x1C, VID7M toggling, WNDW_N=0 → VIDEO = 0,0,1,1,1,0,0, each dot lasting 2 cycles, starting 2 cycles after LDPS_N falls.
- Inverse and flash: code 0x01 → complement of ROM row. Code 0x41 with ALTCHAR=0 → toggles between normal and inverse every 16 VBLANK edges. Code 0x41 with ALTCHAR=1 → never inverted.
- 80-col: aux 0x55, main 0x2A, VID7M=0 → 14 dots at 1 cycle each: 1,0,1,0,1,0,1, then 0,1,0,1,0,1,0.
- Hires delay: main 0x81 vs 0x01 → identical dot pattern, with the 0x81 case shifted one cycle later. With DHIRES_MODE=1 the 0x81 case is not shifted.
- Lores and blanking: byte 0xA3, SEGC=0, SEGA=1 → rotated pattern {1,0,1,1,0,0,1}. WNDW_N=1 at load → VIDEO stays 0 for the whole byte.
